// File: rtl/sm_hex_display.sv
// Multiplexed active-low hex display driver with leading-zero blanking.
// Loads are committed at frame boundaries so a single scan never mixes two values.
module sm_hex_display #(
   parameter int DIGITS        = 8,
   parameter int REFRESH_SHIFT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [31:0]       data,
   input  logic              load,
   input  logic              blank_lz,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = 4 * DIGITS;

   logic [REFRESH_SHIFT-1:0] presc_q, presc_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [DW-1:0]            disp_q, disp_d;
   logic [DW-1:0]            pend_q, pend_d;
   logic                     pend_flag_q, pend_flag_d;
   logic [DIGITS-1:0]        an_q, an_d;
   logic [6:0]               seg_q, seg_d;
   logic                     frame_done_q, frame_done_d;

   logic       tick;
   logic       boundary;
   logic [3:0] nib;
   logic       blank;
   logic       zero_run;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_seg = 7'b1000000;
         4'h1:    hex_seg = 7'b1111001;
         4'h2:    hex_seg = 7'b0100100;
         4'h3:    hex_seg = 7'b0110000;
         4'h4:    hex_seg = 7'b0011001;
         4'h5:    hex_seg = 7'b0010010;
         4'h6:    hex_seg = 7'b0000010;
         4'h7:    hex_seg = 7'b1111000;
         4'h8:    hex_seg = 7'b0000000;
         4'h9:    hex_seg = 7'b0010000;
         4'hA:    hex_seg = 7'b0001000;
         4'hB:    hex_seg = 7'b0000011;
         4'hC:    hex_seg = 7'b1000110;
         4'hD:    hex_seg = 7'b0100001;
         4'hE:    hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   // NOTE: every variable gets a default at the top so no path can infer a latch.
   always_comb begin
      tick         = enable && (presc_q == '1);
      boundary     = tick && (idx_q == IW'(DIGITS - 1));
      presc_d      = presc_q;
      idx_d        = idx_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_flag_d  = pend_flag_q;
      frame_done_d = boundary;

      if (enable) begin
         presc_d = presc_q + 1'b1;
      end
      if (tick) begin
         idx_d = boundary ? '0 : idx_q + 1'b1;
      end

      if (load) begin
         pend_d = data[DW-1:0];
      end
      if (boundary && load) begin
         disp_d      = data[DW-1:0];
         pend_flag_d = 1'b0;
      end else if (boundary && pend_flag_q) begin
         disp_d      = pend_q;
         pend_flag_d = 1'b0;
      end else if (load) begin
         pend_flag_d = 1'b1;
      end
   end

   // NOTE: zero_run is a blocking temporary scanned from the top digit down; only
   // the registers below use non-blocking assignment.
   always_comb begin
      nib      = 4'h0;
      blank    = 1'b0;
      zero_run = 1'b1;
      an_d     = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
         if (idx_q == IW'(i)) begin
            nib   = disp_q[4*i +: 4];
            blank = blank_lz && zero_run && (i != 0);
            an_d[i] = !enable;
         end
      end
      if (!enable) begin
         seg_d = 7'b1111111;
      end else if (blank) begin
         seg_d = 7'b1111111;
      end else begin
         seg_d = hex_seg(nib);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_flag_q  <= 1'b0;
         an_q         <= '1;
         seg_q        <= 7'b1111111;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_flag_q  <= pend_flag_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule
